// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : RV32I fetch stage. Owns the PC, issues in-order instruction
//               memory requests under a credit limit of DEPTH, and queues the
//               returned words for decode as {instr, pc, pc+4}. An execute
//               redirect flushes the queue and drops in-flight responses.
//               Optional macro FETCH_MISALIGN_EN: a misaligned redirect
//               target enters a TRAP state and queues a marked nop.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pcplus4,
    output logic        id_misalign
);

    localparam int              c_cnt_w    = $clog2(DEPTH + 1);
    localparam int              c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(DEPTH - 1);
    localparam logic [31:0]     c_nop      = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [31:0]          r_pc;
    logic [31:0]          r_rsp_pc;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   r_outstanding;
    logic [c_cnt_w-1:0]   r_drop_cnt;
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic                 r_trap_pend;
    logic [31:0]          r_q_instr [DEPTH];
    logic [31:0]          r_q_pc    [DEPTH];
`ifdef FETCH_MISALIGN_EN
    logic                 r_q_mis   [DEPTH];
`endif

    logic [31:0]          w_redir_pc;
    logic                 w_redir_mis;
    logic [c_cnt_w:0]     w_inflight;
    logic                 w_req_valid;
    logic                 w_req_fire;
    logic                 w_rsp_take;
    logic                 w_rsp_push;
    logic                 w_push;
    logic                 w_pop;

`ifdef FETCH_MISALIGN_EN
    assign w_redir_pc  = redirect_pc;
    assign w_redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    // Low target bits are cleared so fetch always stays word aligned.
    assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign w_redir_mis = 1'b0;
`endif

    // Responses with nothing outstanding are stale (e.g. from before a reset).
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req_fire = w_req_valid && imem_req_ready;
    assign w_rsp_take = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_push = w_rsp_take && (r_drop_cnt == '0);
    assign w_push     = !redirect_valid && (w_rsp_push || r_trap_pend);
    assign w_pop      = (r_count != '0) && id_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and request issue; credit counts queued plus in-flight.
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        case (r_state)
            ST_RUN:  w_req_valid = rst_n && !redirect_valid
                                   && (w_inflight < (c_cnt_w + 1)'(DEPTH));
            ST_TRAP: w_req_valid = 1'b0;
            default: w_req_valid = 1'b0;
        endcase
        if (redirect_valid) begin
            w_state_nxt = w_redir_mis ? ST_TRAP : ST_RUN;
        end
    end

    // PCs, counters and queue pointers; a redirect flushes everything at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_trap_pend   <= 1'b0;
        end else if (redirect_valid) begin
            r_pc          <= w_redir_pc;
            r_rsp_pc      <= w_redir_pc;
            r_count       <= '0;
            r_outstanding <= r_outstanding - c_cnt_w'(w_rsp_take);
            r_drop_cnt    <= r_outstanding - c_cnt_w'(w_rsp_take);
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_trap_pend   <= w_redir_mis;
        end else begin
            r_trap_pend   <= 1'b0;
            r_outstanding <= r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(w_rsp_take);
            r_count       <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            if (w_req_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_rsp_take && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            if (w_rsp_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
            if (w_push) begin
                r_wptr <= (r_wptr == c_last_idx) ? '0 : r_wptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_last_idx) ? '0 : r_rptr + c_ptr_w'(1);
            end
        end
    end

    // Queue storage; the trap entry reuses r_pc, which holds the misaligned target.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wptr] <= r_trap_pend ? c_nop : imem_rsp_data;
            r_q_pc[r_wptr]    <= r_trap_pend ? r_pc  : r_rsp_pc;
`ifdef FETCH_MISALIGN_EN
            r_q_mis[r_wptr]   <= r_trap_pend;
`endif
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_pc;
    assign id_valid       = rst_n && (r_count != '0);
    assign id_instr       = rst_n ? r_q_instr[r_rptr] : 32'h0;
    assign id_pc          = rst_n ? r_q_pc[r_rptr] : 32'h0;
    assign id_pcplus4     = rst_n ? (r_q_pc[r_rptr] + 32'd4) : 32'h0;
`ifdef FETCH_MISALIGN_EN
    assign id_misalign    = rst_n && r_q_mis[r_rptr];
`else
    assign id_misalign    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Randomized self-checking bench for instr_fetch_queue with an
//               in-order imem model and a stream-level reference model of the
//               PC sequence delivered to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcplus4;
    logic        id_misalign;

    instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pcplus4     (id_pcplus4),
        .id_misalign    (id_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          n_chk = 0, n_pass = 0, cyc = 0, n_hs = 0, n_pops = 0;
    int          p_ready = 100, p_idready = 100, lat_min = 1, lat_max = 1;
    logic [31:0] fetch_pc = RESET_PC, exp_pc = RESET_PC, trap_pc = '0;
    logic [31:0] last_hs_addr = '0, first_hs_addr = '0, prev_addr = '0, collide_pc = '0;
    bit          trap_mode = 0, trap_entry = 0, prev_redir = 0, prev_stall = 0;
    bit          saw_wrap = 0, want_first = 0, collide_arm = 0, collided = 0;

    // Instruction memory content: a bijection of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_0001;
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n          = 1'b0;
            redirect_valid = 1'($urandom_range(1));
            redirect_pc    = $urandom;
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
            id_ready       = 1'b1;
            #1;
            n_chk++;
            if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0 ||
                id_pc !== 32'h0 || id_pcplus4 !== 32'h0 || id_misalign !== 1'b0)
                $display("FAIL reset_outputs: got req_valid=%b id_valid=%b instr=%h pc=%h pc4=%h mis=%b, want all 0",
                         imem_req_valid, id_valid, id_instr, id_pc, id_pcplus4, id_misalign);
            else n_pass++;
            cyc++;
        end
        pend.delete();
        fetch_pc   = RESET_PC;
        exp_pc     = RESET_PC;
        trap_mode  = 0;
        trap_entry = 0;
        prev_redir = 0;
        prev_stall = 0;
        want_first = 0;
    endtask

    // One clock cycle: drive inputs after negedge, check and update the model.
    task automatic step(input bit redir, input logic [31:0] rpc);
        bit          r, e_any, e_mis;
        logic [31:0] t, e_instr, e_pc;
        @(negedge clk);
        rst_n = 1'b1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = int'($urandom_range(99)) < p_ready;
        id_ready       = int'($urandom_range(99)) < p_idready;
        r = redir;
        t = rpc;
        if (collide_arm && imem_rsp_valid && id_valid) begin
            r = 1'b1; t = collide_pc; id_ready = 1'b1; collide_arm = 0; collided = 1;
        end
        redirect_valid = r;
        redirect_pc    = r ? t : $urandom;
        #1;
        if (prev_redir) begin
            n_chk++;
            if (id_valid !== 1'b0) $display("FAIL id_valid_after_redirect: got %b want 0 (cyc %0d)", id_valid, cyc);
            else n_pass++;
        end
        if (redirect_valid || trap_mode) begin
            n_chk++;
            if (imem_req_valid !== 1'b0)
                $display("FAIL req_blocked: got req_valid=%b want 0 (redirect=%b trap=%0d cyc %0d)",
                         imem_req_valid, redirect_valid, trap_mode, cyc);
            else n_pass++;
        end
        if (prev_stall && !redirect_valid) begin
            n_chk++;
            if (imem_req_valid !== 1'b1 || imem_addr !== prev_addr)
                $display("FAIL addr_hold: got valid=%b addr=%h want valid=1 addr=%h", imem_req_valid, imem_addr, prev_addr);
            else n_pass++;
        end
        if (id_valid === 1'b1) begin
            e_any = 1;
            if (trap_mode) begin
                e_any = trap_entry; e_instr = 32'h13; e_pc = trap_pc; e_mis = 1;
            end else begin
                e_instr = memf(exp_pc); e_pc = exp_pc; e_mis = 0;
            end
            n_chk++;
            if (!e_any || id_instr !== e_instr || id_pc !== e_pc || id_pcplus4 !== e_pc + 32'd4 || id_misalign !== e_mis)
                $display("FAIL head cyc=%0d: got instr=%h pc=%h pc4=%h mis=%b, want instr=%h pc=%h mis=%b entry_expected=%0d",
                         cyc, id_instr, id_pc, id_pcplus4, id_misalign, e_instr, e_pc, e_mis, e_any);
            else n_pass++;
            if (id_ready && !redirect_valid) begin
                n_pops++;
                if (trap_mode) trap_entry = 0;
                else exp_pc = exp_pc + 32'd4;
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            n_chk++;
            if (imem_addr !== fetch_pc) $display("FAIL fetch_addr: got %h want %h", imem_addr, fetch_pc);
            else n_pass++;
            if (n_hs > 0 && imem_addr == 32'h0 && last_hs_addr == 32'hFFFF_FFFC) saw_wrap = 1;
            if (want_first) begin first_hs_addr = imem_addr; want_first = 0; end
            last_hs_addr = imem_addr;
            fetch_pc     = fetch_pc + 32'd4;
            n_hs++;
            pend.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        end
        if (imem_rsp_valid) pend.delete(0);
        n_chk++;
        if (pend.size() > DEPTH) $display("FAIL outstanding_bound: got %0d want <= %0d", pend.size(), DEPTH);
        else n_pass++;
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_EN
            if (redirect_pc[1:0] != 2'b00) begin
                trap_mode = 1; trap_entry = 1; trap_pc = redirect_pc;
            end else begin
                trap_mode = 0; trap_entry = 0; fetch_pc = redirect_pc; exp_pc = redirect_pc;
            end
`else
            fetch_pc = {redirect_pc[31:2], 2'b00};
            exp_pc   = fetch_pc;
`endif
        end
        prev_redir = redirect_valid;
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_addr;
        cyc++;
    endtask

    task automatic test_reset;
        do_reset(3);
        p_ready = 100; p_idready = 0; lat_min = 1; lat_max = 1;
        step(0, 0);
        step(0, 0);
        n_chk++;
        if (imem_rsp_valid !== 1'b1 || id_valid !== 1'b0)
            $display("FAIL no_bypass: got rsp_valid=%b id_valid=%b want 1/0", imem_rsp_valid, id_valid);
        else n_pass++;
        step(0, 0);
        n_chk++;
        if (id_valid !== 1'b1 || id_pc !== RESET_PC)
            $display("FAIL rsp_to_id_latency: got id_valid=%b pc=%h want 1/%h", id_valid, id_pc, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_stream;
        do_reset(1);
        p_ready = 100; p_idready = 100; lat_min = 1; lat_max = 1; n_pops = 0;
        repeat (40) step(0, 0);
        n_chk++;
        if (n_pops < 12) $display("FAIL stream_progress: got %0d pops want >= 12", n_pops);
        else n_pass++;
    endtask

    task automatic test_stall;
        do_reset(1);
        p_ready = 100; p_idready = 0; lat_min = 1; lat_max = 1; n_hs = 0;
        repeat (10) step(0, 0);
        n_chk++;
        if (n_hs != 2 || imem_req_valid !== 1'b0)
            $display("FAIL stall_requests: got %0d handshakes req_valid=%b want 2/0", n_hs, imem_req_valid);
        else n_pass++;
        n_chk++;
        if (id_valid !== 1'b1 || id_pc !== RESET_PC)
            $display("FAIL stall_head: got valid=%b pc=%h want 1/%h", id_valid, id_pc, RESET_PC);
        else n_pass++;
        p_idready = 100; n_pops = 0;
        repeat (20) step(0, 0);
        n_chk++;
        if (n_pops < 6) $display("FAIL stall_release: got %0d pops want >= 6", n_pops);
        else n_pass++;
    endtask

    task automatic test_redirect_outstanding;
        do_reset(1);
        p_ready = 100; p_idready = 100; lat_min = 6; lat_max = 6; n_hs = 0;
        step(0, 0);
        step(0, 0);
        n_chk++;
        if (n_hs != 2) $display("FAIL two_outstanding: got %0d handshakes want 2", n_hs);
        else n_pass++;
        step(1, 32'h100);
        step(0, 0);
        n_chk++;
        if (imem_addr !== 32'h100) $display("FAIL redirect_addr: got %h want 00000100", imem_addr);
        else n_pass++;
        lat_min = 1; lat_max = 1; n_pops = 0;
        repeat (25) step(0, 0);
        n_chk++;
        if (n_pops == 0) $display("FAIL redirect_progress: got 0 pops want > 0");
        else n_pass++;
    endtask

    task automatic test_redirect_collide;
        p_ready = 100; p_idready = 100; lat_min = 1; lat_max = 1;
        collide_pc = 32'h300; collided = 0; collide_arm = 1;
        repeat (20) step(0, 0);
        collide_arm = 0;
        n_chk++;
        if (!collided) $display("FAIL collide_reached: got 0 want 1");
        else n_pass++;
    endtask

    task automatic test_wrap;
        p_ready = 100; p_idready = 100; lat_min = 1; lat_max = 1; saw_wrap = 0;
        step(1, 32'hFFFF_FFF8);
        repeat (15) step(0, 0);
        n_chk++;
        if (!saw_wrap) $display("FAIL pc_wrap: got 0 want 1 (address 0 after FFFFFFFC)");
        else n_pass++;
    endtask

    task automatic test_misalign;
        p_ready = 100; p_idready = 0; lat_min = 1; lat_max = 1;
        step(1, 32'h102);
`ifdef FETCH_MISALIGN_EN
        n_hs = 0;
        repeat (3) step(0, 0);
        n_chk++;
        if (id_valid !== 1'b1 || id_instr !== 32'h13 || id_pc !== 32'h102 || id_misalign !== 1'b1)
            $display("FAIL trap_entry: got valid=%b instr=%h pc=%h mis=%b want 1/00000013/00000102/1",
                     id_valid, id_instr, id_pc, id_misalign);
        else n_pass++;
        p_idready = 100;
        repeat (8) step(0, 0);
        n_chk++;
        if (n_hs != 0) $display("FAIL trap_no_fetch: got %0d handshakes want 0", n_hs);
        else n_pass++;
        want_first = 1;
        step(1, 32'h200);
        repeat (10) step(0, 0);
        n_chk++;
        if (n_hs == 0 || first_hs_addr !== 32'h200)
            $display("FAIL trap_exit_fetch: got %0d handshakes first=%h want >0/00000200", n_hs, first_hs_addr);
        else n_pass++;
`else
        p_idready = 100; want_first = 1;
        repeat (10) step(0, 0);
        n_chk++;
        if (first_hs_addr !== 32'h100) $display("FAIL misalign_forced: got %h want 00000100", first_hs_addr);
        else n_pass++;
`endif
    endtask

    task automatic test_random;
        bit          r;
        logic [31:0] t;
        n_pops = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) begin
                p_ready   = int'($urandom_range(100, 30));
                p_idready = int'($urandom_range(100, 20));
                lat_min   = 1;
                lat_max   = int'($urandom_range(4, 1));
            end
            if ($urandom_range(399) == 0) begin
                do_reset(int'($urandom_range(2, 1)));
            end else begin
                r = ($urandom_range(99) < 3);
                case ($urandom_range(3))
                    0:       t = $urandom;
                    1:       t = 32'hFFFF_FFF0;
                    default: t = 32'h1000 + ($urandom_range(255) << 2);
                endcase
                step(r, t);
            end
        end
        n_chk++;
        if (n_pops < 100) $display("FAIL random_progress: got %0d pops want >= 100", n_pops);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_collide();
        test_wrap();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
